// File: rtl/mux_arbiter.sv
// Four-input round-robin arbiter with a registered one-hot grant, a data mux driven by
// the grant owner, and forced release after MAX_HOLD cycles when another requester waits.
module mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [WIDTH-1:0] out,
  output logic             preempt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] sel_reg, sel_next;
  logic [3:0] gnt_reg, gnt_next;
  logic [7:0] hold_reg, hold_next;
  logic       preempt_reg, preempt_next;

  logic [3:0] rot_req;
  logic [1:0] first_off;
  logic [1:0] pick;
  logic       hold_max;
  logic       others_pending;

  // Rotate the request vector so that bit 0 is always the highest-priority requester.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr_reg + 2'(gi)];
    end
  endgenerate

  always_comb begin
    first_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) first_off = 2'(k);
    end
  end

  assign pick           = ptr_reg + first_off;
  assign hold_max       = (hold_reg == 8'(MAX_HOLD));
  assign others_pending = |(req & ~(4'b0001 << sel_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= 2'd0;
      sel_reg     <= 2'd0;
      gnt_reg     <= 4'd0;
      hold_reg    <= 8'd0;
      preempt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      sel_reg     <= sel_next;
      gnt_reg     <= gnt_next;
      hold_reg    <= hold_next;
      preempt_reg <= preempt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    sel_next     = sel_reg;
    gnt_next     = gnt_reg;
    hold_next    = hold_reg;
    preempt_next = 1'b0;
    case (state_reg)
      IDLE: begin
        gnt_next  = 4'd0;
        hold_next = 8'd0;
        if (|req) begin
          state_next = GRANT;
          sel_next   = pick;
          gnt_next   = 4'b0001 << pick;
          hold_next  = 8'd1;
        end
      end
      GRANT: begin
        if (!req[sel_reg] || (hold_max && others_pending)) begin
          // Every release passes through IDLE, guaranteeing a gap before the next grant.
          state_next   = IDLE;
          gnt_next     = 4'd0;
          hold_next    = 8'd0;
          ptr_next     = sel_reg + 2'd1;
          preempt_next = req[sel_reg];
        end else if (!hold_max) begin
          hold_next = hold_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt     = gnt_reg;
  assign sel     = sel_reg;
  assign valid   = (state_reg == GRANT);
  assign preempt = preempt_reg;

  always_comb begin
    out = '0;
    if (valid) begin
      case (sel_reg)
        2'd0:    out = in0;
        2'd1:    out = in1;
        2'd2:    out = in2;
        default: out = in3;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter: reset, round-robin order, forced release,
// saturation with a sole requester, asynchronous reset mid-grant, and non-owner isolation.
module tb_mux_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 8;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             valid;
  logic [WIDTH-1:0] out;
  logic             preempt;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .gnt(gnt), .sel(sel), .valid(valid), .out(out), .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every-cycle invariants: grant is one-hot or zero, data is zero whenever not valid.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!(gnt == 4'd0 || $onehot(gnt))) begin
        errors++;
        $display("FAIL onehot: gnt=%b required one-hot or zero", gnt);
      end
      checks++;
      if (!valid && out !== '0) begin
        errors++;
        $display("FAIL out_gate: out=%h required 00 while valid=0", out);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'd0;
    #3;
    checks++;
    if ({gnt, sel, valid, preempt} !== 8'd0 || out !== '0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b sel=%0d valid=%b preempt=%b out=%h required all zero",
               gnt, sel, valid, preempt, out);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 4'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: gnt=%b valid=%b required 0000/0", gnt, valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    req = 4'b1010;
    step();
    checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1 || valid !== 1'b1 || out !== 8'h22) begin
      errors++;
      $display("FAIL basic_grant: gnt=%b sel=%0d valid=%b out=%h required 0010/1/1/22",
               gnt, sel, valid, out);
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'd0 || valid !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: gnt=%b valid=%b preempt=%b required 0000/0/0",
               gnt, valid, preempt);
    end
    $display("test_basic done");
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5];
    logic [3:0] exp_gnt;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req = 4'b1111;
      step();
      exp_gnt = 4'b0001 << order[i];
      checks++;
      if (gnt !== exp_gnt || sel !== order[i]) begin
        errors++;
        $display("FAIL rr_grant[%0d]: gnt=%b sel=%0d required %b/%0d", i, gnt, sel, exp_gnt, order[i]);
      end
      req = 4'b1111 & ~exp_gnt;
      step();
      checks++;
      if (gnt !== 4'd0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap[%0d]: gnt=%b valid=%b required 0000/0", i, gnt, valid);
      end
    end
    req = 4'd0;
    step();
    $display("test_round_robin done");
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100 || out !== 8'h33) begin
      errors++;
      $display("FAIL pre_first: gnt=%b out=%h required 0100/33", gnt, out);
    end
    req = 4'b0101;
    for (int c = 2; c <= MAX_HOLD; c++) begin
      step();
      checks++;
      if (gnt !== 4'b0100 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL pre_hold[%0d]: gnt=%b preempt=%b required 0100/0", c, gnt, preempt);
      end
    end
    step();
    checks++;
    if (gnt !== 4'd0 || valid !== 1'b0 || preempt !== 1'b1) begin
      errors++;
      $display("FAIL pre_release: gnt=%b valid=%b preempt=%b required 0000/0/1", gnt, valid, preempt);
    end
    step();
    checks++;
    if (gnt !== 4'b0001 || preempt !== 1'b0 || out !== 8'h11) begin
      errors++;
      $display("FAIL pre_next: gnt=%b preempt=%b out=%h required 0001/0/11", gnt, preempt, out);
    end
    req = 4'd0;
    step();
    $display("test_preempt done");
  endtask

  task automatic test_sole_hold();
    do_reset();
    req = 4'b1000;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++;
      if (gnt !== 4'b1000 || preempt !== 1'b0 || out !== 8'h44) begin
        errors++;
        $display("FAIL sole_hold[%0d]: gnt=%b preempt=%b out=%h required 1000/0/44", c, gnt, preempt, out);
      end
    end
    req = 4'd0;
    step();
    checks++;
    if (gnt !== 4'd0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL sole_release: gnt=%b preempt=%b required 0000/0", gnt, preempt);
    end
    req = 4'b1111;
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL sole_wrap: gnt=%b required 0001", gnt);
    end
    req = 4'd0;
    step();
    $display("test_sole_hold done");
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    step();
    checks++;
    if (sel !== 2'd2 || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL ares_pre: sel=%0d gnt=%b required 2/0100", sel, gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'd0 || out !== '0 || valid !== 1'b0 || preempt !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL ares_drop: gnt=%b out=%h valid=%b preempt=%b sel=%0d required 0000/00/0/0/0",
               gnt, out, valid, preempt, sel);
    end
    req = 4'b0101;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0001 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL ares_restart: gnt=%b preempt=%b required 0001/0", gnt, preempt);
    end
    req = 4'd0;
    step();
    $display("test_async_reset done");
  endtask

  task automatic test_non_owner();
    logic [3:0] pats [4];
    pats[0] = 4'b1010; pats[1] = 4'b0110; pats[2] = 4'b1111; pats[3] = 4'b0011;
    do_reset();
    req = 4'b0010;
    step();
    for (int i = 0; i < 4; i++) begin
      req = pats[i];
      step();
      checks++;
      if (gnt !== 4'b0010 || sel !== 2'd1 || out !== 8'h22) begin
        errors++;
        $display("FAIL non_owner[%0d]: gnt=%b sel=%0d out=%h required 0010/1/22", i, gnt, sel, out);
      end
    end
    req = 4'd0;
    step();
    $display("test_non_owner done");
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'd0;
    in0   = 8'h11;
    in1   = 8'h22;
    in2   = 8'h33;
    in3   = 8'h44;
    mon_en = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_preempt();
    test_sole_hold();
    test_async_reset();
    test_non_owner();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 1, bit width of each data input and of out.
REQ-002 SHALL have parameter: MAX_HOLD, 8, maximum consecutive GRANT cycles before forced release when another requester waits (legal range 2..255).
REQ-003 SHALL have port: clk  input  1  single clock, rising-edge active.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: req  input  4  request vector, bit i = requester i.
REQ-006 SHALL have ports: in0, in1, in2, in3  input  WIDTH each  requester data.
REQ-007 SHALL have port: gnt  output  4  one-hot grant, registered.
REQ-008 SHALL have port: sel  output  2  registered mux select = index of current owner.
REQ-009 SHALL have port: valid  output  1  high while in GRANT state.
REQ-010 SHALL have port: out  output  WIDTH  selected data while valid, else all zeros.
REQ-011 SHALL have port: preempt  output  1  one-cycle pulse when a grant is force-released.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-013 SHALL hold a 2-bit round-robin pointer ptr; priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 In IDLE with req != 0, SHALL at the next edge enter GRANT, set sel to the first requesting index in priority order, and set gnt = 1<<sel; grant latency is one cycle.
REQ-015 In IDLE with req == 0, SHALL remain in IDLE with gnt = 0, valid = 0.
REQ-016 out SHALL be combinational from the registered sel: in0/in1/in2/in3 for sel 0/1/2/3, gated to zero when valid = 0.
REQ-017 In GRANT, SHALL hold sel and gnt stable while req[sel] = 1 and no forced release applies.
REQ-018 In GRANT with req[sel] = 0, SHALL return to IDLE at the next edge, clear gnt, and set ptr = sel+1 (wrap 3 -> 0).
REQ-019 SHALL count GRANT cycles in a hold counter: 1 on the first GRANT cycle, saturating at MAX_HOLD.
REQ-020 When hold count = MAX_HOLD, req[sel] = 1, and any other req bit = 1, SHALL return to IDLE at the next edge, set ptr = sel+1, and pulse preempt for that one cycle.
REQ-021 When hold count = MAX_HOLD and no other requester is pending, SHALL keep the grant with the counter saturated; release then follows REQ-018 or REQ-020.
REQ-022 After any release, SHALL spend at least one IDLE cycle (gnt = 0) before the next grant, including re-grant to the same requester.
REQ-023 Request changes on non-owner bits during GRANT SHALL NOT affect sel, gnt, or out.
REQ-024 gnt SHALL never have more than one bit set.

Reset
REQ-025 On rst_n = 0, SHALL asynchronously force state IDLE, ptr = 0, sel = 0, gnt = 0, valid = 0, preempt = 0, hold counter = 0; out = 0.
REQ-026 Reset asserted mid-GRANT SHALL drop the grant immediately without a preempt pulse; after release, arbitration restarts from ptr = 0.

Verification
REQ-027 Reset, then req = 4'b1010 -> one cycle later gnt = 4'b0010, sel = 1, valid = 1, out = in1.
REQ-028 req = 4'b1111 held, each owner drops its bit for one cycle after being granted -> grant order 0, 1, 2, 3, 0 with one IDLE cycle between grants.
REQ-029 Owner 2 holds req while req[0] = 1, MAX_HOLD = 8 -> after 8 GRANT cycles preempt pulses once, then gnt = 4'b0001 after one IDLE cycle.
REQ-030 Sole requester 3 holds for 20 cycles -> gnt = 4'b1000 throughout, preempt never asserts; on release ptr wraps to 0.
REQ-031 rst_n pulsed low mid-GRANT with sel = 2 -> gnt = 0, out = 0 asynchronously; after release with req = 4'b0101, gnt = 4'b0001.
REQ-032 Bench SHALL check every cycle that gnt is one-hot or zero and that out = 0 whenever valid = 0.
